// File: rtl/seq_comparator.sv
// Chunked MSB-first magnitude comparator with a start/done handshake and one-hot eq/lt/gt flags.
// Optional build macro SEQ_COMPARATOR_EARLY_EXIT_EN ends RUN on the first differing slice.
//   state  | meaning
//   S_IDLE | waiting for start; flags hold the last result
//   S_RUN  | resolving one CHUNK-bit slice per cycle, MSB slice first
//   S_DONE | one-cycle done pulse; new flags visible; start accepted back-to-back
module seq_comparator #(
  parameter int WIDTH = 20,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               decided_q, decided_d;
  logic               lt_r_q, lt_r_d;
  logic               eq_q, eq_d;
  logic               lt_q, lt_d;
  logic               gt_q, gt_d;

  logic [CHUNK-1:0]   a_sl, b_sl;
  logic               sl_diff;
  logic               dec_nxt;
  logic               lt_nxt;
  logic               last_slice;

  assign a_sl    = a_q[idx_q*CHUNK +: CHUNK];
  assign b_sl    = b_q[idx_q*CHUNK +: CHUNK];
  assign sl_diff = (a_sl != b_sl);
  // A decided result is sticky; lower slices cannot override it.
  assign dec_nxt = decided_q | sl_diff;
  assign lt_nxt  = decided_q ? lt_r_q : (sl_diff & (a_sl < b_sl));

`ifdef SEQ_COMPARATOR_EARLY_EXIT_EN
  assign last_slice = (idx_q == '0) | (~decided_q & sl_diff);
`else
  assign last_slice = (idx_q == '0);
`endif

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    idx_d     = idx_q;
    decided_d = decided_q;
    lt_r_d    = lt_r_q;
    eq_d      = eq_q;
    lt_d      = lt_q;
    gt_d      = gt_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          // Offset-binary: flipping the sign bits makes a signed compare unsigned.
          a_d = a;
          b_d = b;
          if (signed_mode) begin
            a_d[WIDTH-1] = ~a[WIDTH-1];
            b_d[WIDTH-1] = ~b[WIDTH-1];
          end
          idx_d     = IDX_W'(NCHUNK - 1);
          decided_d = 1'b0;
          lt_r_d    = 1'b0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        decided_d = dec_nxt;
        lt_r_d    = lt_nxt;
        if (last_slice) begin
          state_d = S_DONE;
          eq_d    = ~dec_nxt;
          lt_d    = lt_nxt;
          gt_d    = dec_nxt & ~lt_nxt;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      decided_q <= 1'b0;
      lt_r_q    <= 1'b0;
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
      gt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      idx_q     <= idx_d;
      decided_q <= decided_d;
      lt_r_q    <= lt_r_d;
      eq_q      <= eq_d;
      lt_q      <= lt_d;
      gt_q      <= gt_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign eq   = eq_q;
  assign lt   = lt_q;
  assign gt   = gt_q;

endmodule

// File: tb/tb_seq_comparator.sv
// Scoreboard bench for seq_comparator (WIDTH=20, CHUNK=4): stimulus pushes expected flags and done cycle,
// a monitor pops and compares on every done pulse.
module tb_seq_comparator;

  localparam int WIDTH  = 20;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             signed_mode = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy, done, eq, lt, gt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [2:0] flags;  // {eq, lt, gt}
    int         cyc;
    string      name;
  } exp_t;

  exp_t sb[$];

  seq_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy), .done(done), .eq(eq), .lt(lt), .gt(gt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int lat(input int k);
`ifdef SEQ_COMPARATOR_EARLY_EXIT_EN
    return k + 1;
`else
    return NCHUNK + 1;
`endif
  endfunction

  // Caller is positioned at a negedge; returns one negedge later with start dropped.
  task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib, input logic sm,
                       input logic [2:0] f, input int k, input string nm);
    exp_t e;
    a = ia; b = ib; signed_mode = sm; start = 1'b1;
    e.flags = f; e.cyc = cyc + lat(k); e.name = nm;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk({nm, "_timeout"}, 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      chk("done_expected", 32'(sb.size() != 0), 32'd1);
      chk("busy_in_done", 32'(busy), 32'd0);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_flags"}, 32'({eq, lt, gt}), 32'(e.flags));
        chk({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got stuck at cyc %0d expected completion", cyc);
    $fatal(1);
  end

  initial begin
    int c0;
    // 1. reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_eq", 32'(eq), 32'd0);
    chk("rst_lt", 32'(lt), 32'd0);
    chk("rst_gt", 32'(gt), 32'd0);

    // 2. unsigned near-equal, busy window T+1..T+5
    c0 = cyc;
    issue(20'h12345, 20'h12346, 1'b0, 3'b010, 5, "near_eq");
    for (int i = 1; i <= NCHUNK; i++) begin
      chk($sformatf("near_eq_busy_t%0d", cyc - c0), 32'(busy), 32'd1);
      @(negedge clk);
    end
    drain("near_eq");

    // 3. sign mode
    issue(20'hFFFFF, 20'h00001, 1'b1, 3'b010, 1, "signed_m1_vs_1");
    drain("signed_m1_vs_1");
    issue(20'hFFFFF, 20'h00001, 1'b0, 3'b001, 1, "unsigned_max_vs_1");
    drain("unsigned_max_vs_1");
    issue(20'h80000, 20'h7FFFF, 1'b1, 3'b010, 1, "signed_min_vs_max");
    drain("signed_min_vs_max");

    // 4. equal operands, both modes; operand change after acceptance is ignored
    issue(20'hABCDE, 20'hABCDE, 1'b0, 3'b100, 5, "eq_unsigned");
    drain("eq_unsigned");
    issue(20'hABCDE, 20'hABCDE, 1'b1, 3'b100, 5, "eq_signed");
    @(negedge clk);
    a = '0;
    drain("eq_late_change");

    // 5. early exit candidate; previous eq flags must hold into the next RUN
    issue(20'h80000, 20'h00000, 1'b0, 3'b001, 1, "msb_gt");
    chk("hold_flags_in_run", 32'({eq, lt, gt}), 32'(3'b100));
    drain("msb_gt");
    chk("hold_flags_in_idle", 32'({eq, lt, gt}), 32'(3'b001));

    // 6a. start held high: a new compare every NCHUNK+1 cycles
    begin
      exp_t e;
      c0 = cyc;
      a = 20'h0F0F0; b = 20'h0F0F0; signed_mode = 1'b0; start = 1'b1;
      for (int i = 1; i <= 3; i++) begin
        e.flags = 3'b100; e.cyc = c0 + i * lat(5); e.name = $sformatf("b2b_%0d", i);
        sb.push_back(e);
      end
      repeat (3 * lat(5)) @(negedge clk);
      start = 1'b0;
      drain("b2b");
    end

    // 6b. start during RUN is ignored
    issue(20'h00001, 20'h00002, 1'b0, 3'b010, 5, "run_start_ignored");
    repeat (2) @(negedge clk);
    a = 20'hFFFFF; b = 20'h00000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain("run_start_ignored");
    repeat (10) @(negedge clk);
    chk("ignored_keeps_lt", 32'({eq, lt, gt}), 32'(3'b010));

    // 6c. reset mid-RUN aborts with no done and cleared flags
    issue(20'h00005, 20'h00003, 1'b0, 3'b001, 5, "abort");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(sb.pop_back());
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_flags", 32'({eq, lt, gt}), 32'd0);
    repeat (10) @(negedge clk);
    chk("abort_no_done_flags", 32'({eq, lt, gt}), 32'd0);
    chk("abort_idle", 32'({busy, done}), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
